// File: rtl/priority_arbiter_rr_if.sv
// Grant handshake bundle between request sources, the arbiter and the grant consumer.
// The master side is the arbiter and the slave side is the environment.
interface priority_arbiter_rr_if #(
    parameter int WIDTH     = 16,
    parameter int WIDTH_LOG = $clog2(WIDTH)
);
    logic [WIDTH-1:0]     req;
    logic                 grt_vld;
    logic                 grt_rdy;
    logic [WIDTH_LOG-1:0] grt_idx;
    logic [WIDTH-1:0]     grt_oht;

    modport master (
        input  req,
        input  grt_rdy,
        output grt_vld,
        output grt_idx,
        output grt_oht
    );

    modport slave (
        output req,
        output grt_rdy,
        input  grt_vld,
        input  grt_idx,
        input  grt_oht
    );
endinterface

// File: rtl/priority_arbiter_rr.sv
// Registered fixed-priority / round-robin arbiter built on a SPLIT-way tree priority encoder.
// The grant is held stable while the consumer applies backpressure.
module priority_arbiter_rr #(
    parameter int WIDTH     = 16,
    parameter int SPLIT     = 4,
    parameter int MODE      = 1,
    parameter int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    priority_arbiter_rr_if.master bus,
    output logic [WIDTH_LOG-1:0]  ptr
);

    function automatic int calc_leaves(input int w, input int s);
        int n;
        n = 1;
        while (n < w) n = n * s;
        return n;
    endfunction

    function automatic int calc_levels(input int w, input int s);
        int n;
        int l;
        n = 1;
        l = 0;
        while (n < w) begin
            n = n * s;
            l = l + 1;
        end
        return l;
    endfunction

    localparam int LEAVES = calc_leaves(WIDTH, SPLIT);
    localparam int LEVELS = calc_levels(WIDTH, SPLIT);
    localparam int LEAF_W = $clog2(LEAVES);

    // Each tree node keeps the lowest valid child of its SPLIT-wide group; result is {found, index}.
    function automatic logic [WIDTH_LOG:0] tree_encode(input logic [WIDTH-1:0] v);
        logic [LEAVES-1:0] vld;
        logic [LEAF_W-1:0] ix [LEAVES];
        logic              tv;
        logic [LEAF_W-1:0] ti;
        int                stride;
        vld = LEAVES'(v);
        for (int i = 0; i < LEAVES; i++) begin
            ix[i] = LEAF_W'(i);
        end
        stride = 1;
        for (int l = 0; l < LEVELS; l++) begin
            for (int p = 0; p < LEAVES; p += stride * SPLIT) begin
                tv = 1'b0;
                ti = '0;
                for (int c = SPLIT - 1; c >= 0; c--) begin
                    if (vld[p + c * stride]) begin
                        tv = 1'b1;
                        ti = ix[p + c * stride];
                    end
                end
                vld[p] = tv;
                ix[p]  = ti;
            end
            stride = stride * SPLIT;
        end
        return {vld[0], ix[0][WIDTH_LOG-1:0]};
    endfunction

    logic                 hs;
    logic                 any;
    logic                 vld_d, vld_q;
    logic [WIDTH_LOG-1:0] ptr_d, ptr_q;
    logic [WIDTH_LOG-1:0] idx_d, idx_q;
    logic [WIDTH_LOG-1:0] sel;
    logic [WIDTH-1:0]     oht_d, oht_q;
    logic [WIDTH-1:0]     mask;
    logic [WIDTH-1:0]     req_hi;
    logic [WIDTH_LOG:0]   enc_hi;
    logic [WIDTH_LOG:0]   enc_all;

    assign hs = vld_q & bus.grt_rdy;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (hs && MODE == 1) begin
            ptr_d = (idx_q == WIDTH_LOG'(WIDTH - 1)) ? '0 : idx_q + WIDTH_LOG'(1);
        end
    end

    // Rotating search: first try bits at or above the pointer, then fall back to the full vector.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (WIDTH_LOG'(i) >= ptr_d);
        end
        req_hi  = bus.req & mask;
        enc_hi  = tree_encode(req_hi);
        enc_all = tree_encode(bus.req);
        any     = enc_all[WIDTH_LOG];
        sel     = enc_hi[WIDTH_LOG] ? enc_hi[WIDTH_LOG-1:0] : enc_all[WIDTH_LOG-1:0];
    end

    always_comb begin
        vld_d = vld_q;
        idx_d = idx_q;
        oht_d = oht_q;
        if (clr) begin
            vld_d = 1'b0;
            idx_d = '0;
            oht_d = '0;
        end else if (!vld_q || hs) begin
            vld_d = any;
            idx_d = sel;
            for (int i = 0; i < WIDTH; i++) begin
                oht_d[i] = any && (sel == WIDTH_LOG'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            vld_q <= 1'b0;
            idx_q <= '0;
            oht_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            idx_q <= idx_d;
            oht_q <= oht_d;
        end
    end

    assign bus.grt_vld = vld_q;
    assign bus.grt_idx = idx_q;
    assign bus.grt_oht = oht_q;
    assign ptr         = ptr_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Three arbiter instances (16-wide round-robin, 16-wide fixed, 5-wide round-robin) checked
// against directed vector tables and a rotating-search reference model.
module tb_priority_arbiter_rr;

    typedef struct {
        int          dut;
        logic [15:0] req;
        logic        rdy;
        logic        clr;
        logic        exp_vld;
        int          exp_idx;
        int          exp_ptr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] req_v [3];
    logic        rdy_v [3];
    logic        clr_v [3];
    logic [3:0]  ptr_a;
    logic [3:0]  ptr_b;
    logic [2:0]  ptr_c;

    int checks = 0;
    int errors = 0;

    bit m_vld [3];
    int m_idx [3];
    int m_ptr [3];

    priority_arbiter_rr_if #(.WIDTH(16)) if_a ();
    priority_arbiter_rr_if #(.WIDTH(16)) if_b ();
    priority_arbiter_rr_if #(.WIDTH(5))  if_c ();

    assign if_a.req     = req_v[0];
    assign if_a.grt_rdy = rdy_v[0];
    assign if_b.req     = req_v[1];
    assign if_b.grt_rdy = rdy_v[1];
    assign if_c.req     = req_v[2][4:0];
    assign if_c.grt_rdy = rdy_v[2];

    priority_arbiter_rr #(.WIDTH(16), .SPLIT(4), .MODE(1)) u_a (
        .clk (clk),
        .rst (rst),
        .clr (clr_v[0]),
        .bus (if_a),
        .ptr (ptr_a)
    );

    priority_arbiter_rr #(.WIDTH(16), .SPLIT(3), .MODE(0)) u_b (
        .clk (clk),
        .rst (rst),
        .clr (clr_v[1]),
        .bus (if_b),
        .ptr (ptr_b)
    );

    priority_arbiter_rr #(.WIDTH(5), .SPLIT(2), .MODE(1)) u_c (
        .clk (clk),
        .rst (rst),
        .clr (clr_v[2]),
        .bus (if_c),
        .ptr (ptr_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic get_act(input int k, output logic [31:0] vld, output logic [31:0] idx,
                           output logic [31:0] oht, output logic [31:0] p);
        case (k)
            0: begin
                vld = 32'(if_a.grt_vld); idx = 32'(if_a.grt_idx);
                oht = 32'(if_a.grt_oht); p   = 32'(ptr_a);
            end
            1: begin
                vld = 32'(if_b.grt_vld); idx = 32'(if_b.grt_idx);
                oht = 32'(if_b.grt_oht); p   = 32'(ptr_b);
            end
            default: begin
                vld = 32'(if_c.grt_vld); idx = 32'(if_c.grt_idx);
                oht = 32'(if_c.grt_oht); p   = 32'(ptr_c);
            end
        endcase
    endtask

    // Reference: linear search from the pointer, wrapping modulo the width.
    task automatic model_step(input int k);
        int w;
        int np;
        int j;
        bit hs;
        w = (k == 2) ? 5 : 16;
        if (!rst || clr_v[k]) begin
            m_vld[k] = 1'b0;
            m_idx[k] = 0;
            m_ptr[k] = 0;
            return;
        end
        hs = m_vld[k] && rdy_v[k];
        np = (hs && k != 1) ? (m_idx[k] + 1) % w : m_ptr[k];
        if (!m_vld[k] || hs) begin
            m_vld[k] = 1'b0;
            m_idx[k] = 0;
            for (int s = 0; s < w; s++) begin
                j = (np + s) % w;
                if (req_v[k][j]) begin
                    m_vld[k] = 1'b1;
                    m_idx[k] = j;
                    break;
                end
            end
        end
        m_ptr[k] = np;
    endtask

    task automatic check_output(input int k, input string name, input logic exp_vld,
                                input int exp_idx, input int exp_ptr);
        logic [31:0] vld, idx, oht, p;
        logic [31:0] exp_oht;
        exp_oht = exp_vld ? (32'd1 << exp_idx) : 32'd0;
        get_act(k, vld, idx, oht, p);
        check($sformatf("%s dut%0d vld", name, k), vld, 32'(exp_vld));
        check($sformatf("%s dut%0d idx", name, k), idx, 32'(exp_idx));
        check($sformatf("%s dut%0d oht", name, k), oht, exp_oht);
        check($sformatf("%s dut%0d ptr", name, k), p, 32'(exp_ptr));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_output(k, "model", m_vld[k], m_idx[k], m_ptr[k]);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        req_v[v.dut] = v.req;
        rdy_v[v.dut] = v.rdy;
        clr_v[v.dut] = v.clr;
        tick();
    endtask

    vec_t tbl [$];

    initial begin
        // Directed rows: clr + sparse rotation, backpressure hold, then the 5-wide wrap case.
        tbl.push_back('{0, 16'h8101, 1'b1, 1'b1, 1'b0,  0, 0});
        tbl.push_back('{0, 16'h8101, 1'b1, 1'b0, 1'b1,  0, 0});
        tbl.push_back('{0, 16'h8101, 1'b1, 1'b0, 1'b1,  8, 1});
        tbl.push_back('{0, 16'h8101, 1'b1, 1'b0, 1'b1, 15, 9});
        tbl.push_back('{0, 16'h8101, 1'b1, 1'b0, 1'b1,  0, 0});
        tbl.push_back('{0, 16'h8101, 1'b1, 1'b0, 1'b1,  8, 1});
        tbl.push_back('{0, 16'h8101, 1'b1, 1'b0, 1'b1, 15, 9});
        tbl.push_back('{0, 16'h0101, 1'b1, 1'b0, 1'b1,  0, 0});
        tbl.push_back('{0, 16'h0030, 1'b0, 1'b1, 1'b0,  0, 0});
        tbl.push_back('{0, 16'h0030, 1'b0, 1'b0, 1'b1,  4, 0});
        tbl.push_back('{0, 16'h0030, 1'b0, 1'b0, 1'b1,  4, 0});
        tbl.push_back('{0, 16'h0030, 1'b0, 1'b0, 1'b1,  4, 0});
        tbl.push_back('{0, 16'h0001, 1'b0, 1'b0, 1'b1,  4, 0});
        tbl.push_back('{0, 16'h0001, 1'b0, 1'b0, 1'b1,  4, 0});
        tbl.push_back('{0, 16'h0001, 1'b1, 1'b0, 1'b1,  0, 5});
        tbl.push_back('{0, 16'h0000, 1'b0, 1'b0, 1'b1,  0, 5});
        tbl.push_back('{0, 16'h0000, 1'b1, 1'b0, 1'b0,  0, 1});
        tbl.push_back('{2, 16'h0004, 1'b0, 1'b0, 1'b1,  2, 0});
        tbl.push_back('{2, 16'h0008, 1'b1, 1'b0, 1'b1,  3, 3});
        tbl.push_back('{2, 16'h0008, 1'b0, 1'b0, 1'b1,  3, 3});
        tbl.push_back('{2, 16'h0008, 1'b0, 1'b1, 1'b0,  0, 0});
        tbl.push_back('{2, 16'h0010, 1'b1, 1'b0, 1'b1,  4, 0});
        tbl.push_back('{2, 16'h0010, 1'b1, 1'b0, 1'b1,  4, 0});
        tbl.push_back('{2, 16'h0000, 1'b1, 1'b0, 1'b0,  0, 0});

        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_v[k] = 16'hFFFF;
            rdy_v[k] = 1'b1;
            clr_v[k] = 1'b0;
            m_vld[k] = 1'b0;
            m_idx[k] = 0;
            m_ptr[k] = 0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) check_output(k, "reset", 1'b0, 0, 0);

        rst = 1'b1;
        for (int k = 0; k < 3; k++) req_v[k] = 16'h0000;
        for (int t = 0; t < 4; t++) tick();
        for (int k = 0; k < 3; k++) check_output(k, "idle", 1'b0, 0, 0);

        req_v[0] = 16'hFFFF;
        for (int t = 1; t <= 32; t++) begin
            tick();
            check_output(0, $sformatf("sweep%0d", t), 1'b1, (t - 1) % 16, (t - 1) % 16);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i]);
            check_output(tbl[i].dut, $sformatf("vec%0d", i), tbl[i].exp_vld,
                         tbl[i].exp_idx, tbl[i].exp_ptr);
        end

        req_v[1] = 16'h00C0;
        for (int t = 0; t < 8; t++) begin
            tick();
            check_output(1, $sformatf("fixed%0d", t), 1'b1, 6, 0);
        end

        req_v[2] = 16'h001F;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check_output(2, $sformatf("sweep5_%0d", t), 1'b1, (t - 1) % 5, (t - 1) % 5);
        end

        // Exhaustive fixed-priority walk on dut1 while dut0/dut2 see random traffic.
        for (int v = 0; v < 65536; v++) begin
            req_v[1] = 16'(v);
            rdy_v[1] = 1'b1;
            req_v[0] = 16'($urandom & $urandom);
            rdy_v[0] = ($urandom_range(0, 3) != 0);
            clr_v[0] = ($urandom_range(0, 63) == 0);
            req_v[2] = 16'($urandom_range(0, 31));
            rdy_v[2] = ($urandom_range(0, 3) != 0);
            clr_v[2] = ($urandom_range(0, 63) == 0);
            tick();
        end

        for (int k = 0; k < 3; k++) begin
            req_v[k] = 16'hFFFF;
            rdy_v[k] = 1'b0;
            clr_v[k] = 1'b0;
        end
        tick();
        tick();
        check("pending a vld", 32'(if_a.grt_vld), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_output(k, "async_rst", 1'b0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        check_output(0, "post_rst", 1'b1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
